// File: rtl/bcd_serial_subtractor.sv
// Digit-serial BCD subtractor: A - B via A + 9's-complement(B) + 1, LSD first,
// with a second serial pass that recomplements negative results to magnitude.
module bcd_serial_subtractor #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clock,
    input  logic                  reset_b,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a_bcd,
    input  logic [4*DIGITS-1:0]   b_bcd,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   result,
    output logic                  negative,
    output logic                  err
);

    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        SUB,
        CHECK,
        RECOMP,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [4*DIGITS-1:0]   a_q, a_d;
    logic [4*DIGITS-1:0]   b_q, b_d;
    logic [4*DIGITS-1:0]   result_q, result_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  carry_q, carry_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  negative_q, negative_d;
    logic                  err_q, err_d;

    logic [3:0]            cur_a, cur_b, cur_r;
    logic [4:0]            sum;
    logic                  bad_digit;

    // {carry_out, digit} of a + (9 - b) + cin with BCD correction
    function automatic logic [4:0] bcd_digit(input logic [3:0] a,
                                             input logic [3:0] b,
                                             input logic       cin);
        logic [4:0] s;
        logic [4:0] t;
        s = {1'b0, a} + (5'd9 - {1'b0, b}) + {4'b0000, cin};
        t = s + 5'd6;
        if (s > 5'd9) begin
            return {1'b1, t[3:0]};
        end
        return {1'b0, s[3:0]};
    endfunction

    always_comb begin
        cur_a     = '0;
        cur_b     = '0;
        cur_r     = '0;
        bad_digit = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_a = a_q[4*i +: 4];
                cur_b = b_q[4*i +: 4];
                cur_r = result_q[4*i +: 4];
            end
            if (a_bcd[4*i +: 4] > 4'd9 || b_bcd[4*i +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        result_d   = result_q;
        idx_d      = idx_q;
        carry_d    = carry_q;
        busy_d     = busy_q;
        done_d     = done_q;
        negative_d = negative_q;
        err_d      = err_q;
        sum        = '0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d        = a_bcd;
                    b_d        = b_bcd;
                    err_d      = bad_digit;
                    negative_d = 1'b0;
                    carry_d    = 1'b1;
                    idx_d      = '0;
                    busy_d     = 1'b1;
                    state_d    = SUB;
                end
            end
            SUB: begin
                sum     = bcd_digit(cur_a, cur_b, carry_q);
                carry_d = sum[4];
                for (int unsigned i = 0; i < DIGITS; i++) begin
                    if (idx_q == IW'(i)) result_d[4*i +: 4] = sum[3:0];
                end
                if (idx_q == LAST) begin
                    state_d = CHECK;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            CHECK: begin
                if (carry_q) begin
                    negative_d = 1'b0;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = DONE;
                end else begin
                    negative_d = 1'b1;
                    carry_d    = 1'b1;
                    idx_d      = '0;
                    state_d    = RECOMP;
                end
            end
            RECOMP: begin
                // 0 + (9 - r) + carry reuses the subtract digit path
                sum     = bcd_digit(4'd0, cur_r, carry_q);
                carry_d = sum[4];
                for (int unsigned i = 0; i < DIGITS; i++) begin
                    if (idx_q == IW'(i)) result_d[4*i +: 4] = sum[3:0];
                end
                if (idx_q == LAST) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                done_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_b) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            result_q   <= '0;
            idx_q      <= '0;
            carry_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            negative_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            result_q   <= result_d;
            idx_q      <= idx_d;
            carry_q    <= carry_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            negative_q <= negative_d;
            err_q      <= err_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign negative = negative_q;
    assign err      = err_q;

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Self-checking bench: directed cases plus random BCD operands compared against
// an integer-arithmetic model of A - B in sign-magnitude.
module tb_bcd_serial_subtractor;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned W = 4 * DIGITS;

    logic         clock;
    logic         reset_b;
    logic         start;
    logic [W-1:0] a_bcd;
    logic [W-1:0] b_bcd;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         negative;
    logic         err;

    int checks = 0;
    int errors = 0;

    bcd_serial_subtractor #(.DIGITS(DIGITS)) dut (
        .clock    (clock),
        .reset_b  (reset_b),
        .start    (start),
        .a_bcd    (a_bcd),
        .b_bcd    (b_bcd),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .negative (negative),
        .err      (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic int from_bcd(input logic [W-1:0] v);
        int r;
        r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r;
        for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    function automatic logic has_bad(input logic [W-1:0] a, input logic [W-1:0] b);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad = 1'b1;
        return bad;
    endfunction

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit poke_start);
        int  av, bv, lat, exp_lat;
        bit  got, busy_ok, exp_err, exp_neg;
        logic [W-1:0] exp_res;

        exp_err = has_bad(a, b);
        av      = from_bcd(a);
        bv      = from_bcd(b);
        exp_neg = (av < bv);
        exp_res = to_bcd(exp_neg ? bv - av : av - bv);
        exp_lat = exp_neg ? 2 * DIGITS + 1 : DIGITS + 1;

        a_bcd = a;
        b_bcd = b;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        a_bcd = rand_bcd();
        b_bcd = rand_bcd();
        check_eq({tag, "_busy_start"}, 32'(busy), 32'd1);

        lat = 0;
        got = 1'b0;
        busy_ok = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            if (poke_start && n == 3) begin
                start = 1'b1;
                a_bcd = to_bcd(1);
                b_bcd = to_bcd(2);
            end
            @(posedge clock);
            #1;
            start = 1'b0;
            if (done) begin
                lat = n;
                got = 1'b1;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end

        check_eq({tag, "_done_seen"}, 32'(got), 32'd1);
        check_eq({tag, "_busy_during"}, 32'(busy_ok), 32'd1);
        check_eq({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        check_eq({tag, "_err"}, 32'(err), 32'(exp_err));
        if (exp_err) begin
            check_eq({tag, "_lat_err"}, 32'(lat == DIGITS + 1 || lat == 2 * DIGITS + 1), 32'd1);
        end else begin
            check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
            check_eq({tag, "_result"}, 32'(result), 32'(exp_res));
            check_eq({tag, "_negative"}, 32'(negative), 32'(exp_neg));
        end

        @(posedge clock);
        #1;
        check_eq({tag, "_done_pulse"}, 32'(done), 32'd0);
        if (!exp_err) begin
            check_eq({tag, "_result_hold"}, 32'(result), 32'(exp_res));
            check_eq({tag, "_neg_hold"}, 32'(negative), 32'(exp_neg));
        end
        if (poke_start) begin
            @(posedge clock);
            #1;
            check_eq({tag, "_no_restart"}, 32'(busy), 32'd0);
        end
    endtask

    task automatic reset_mid_recomp();
        int dones;
        a_bcd = to_bcd(17);
        b_bcd = to_bcd(42);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        // edge DIGITS+1 enters RECOMP; one more edge is inside it
        for (int n = 1; n <= DIGITS + 2; n++) begin
            @(posedge clock);
            #1;
        end
        reset_b = 1'b0;
        @(posedge clock);
        #1;
        reset_b = 1'b1;
        check_eq("rst_mid_busy", 32'(busy), 32'd0);
        check_eq("rst_mid_done", 32'(done), 32'd0);
        check_eq("rst_mid_result", 32'(result), 32'd0);
        check_eq("rst_mid_neg", 32'(negative), 32'd0);
        dones = 0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clock);
            #1;
            if (done) dones++;
        end
        check_eq("rst_mid_no_done", 32'(dones), 32'd0);
    endtask

    task automatic start_held_high();
        int dones;
        int accepted_edge;
        a_bcd = to_bcd(42);
        b_bcd = to_bcd(17);
        start = 1'b1;
        dones = 0;
        accepted_edge = -1;
        for (int n = 0; n < 40; n++) begin
            @(posedge clock);
            #1;
            if (done) dones++;
            if (dones == 1 && accepted_edge < 0 && busy) accepted_edge = n;
        end
        start = 1'b0;
        // done at edge 5, DONE->IDLE at 6, re-accepted at 7
        check_eq("held_restart_edge", 32'(accepted_edge), 32'(2 * (DIGITS + 1) - 3));
        check_eq("held_multi_done", 32'(dones >= 2), 32'd1);
        for (int n = 0; n < 20 && busy; n++) begin
            @(posedge clock);
            #1;
        end
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        check_eq("held_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        reset_b = 1'b0;
        start   = 1'b0;
        a_bcd   = '0;
        b_bcd   = '0;
        @(posedge clock);
        @(posedge clock);
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_result", 32'(result), 32'd0);
        check_eq("rst_neg", 32'(negative), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        reset_b = 1'b1;
        @(posedge clock);
        #1;

        run_op("pos", 16'h0042, 16'h0017, 1'b0);
        run_op("neg", 16'h0017, 16'h0042, 1'b0);
        run_op("eq", 16'h1234, 16'h1234, 1'b0);
        run_op("max_neg", 16'h0000, 16'h9999, 1'b0);
        run_op("chain", 16'h1000, 16'h0001, 1'b0);
        run_op("poke", 16'h0305, 16'h0128, 1'b1);
        reset_mid_recomp();
        run_op("bad", 16'h00A0, 16'h0001, 1'b0);
        run_op("zero", 16'h0000, 16'h0000, 1'b0);

        for (int k = 0; k < 40; k++) begin
            logic [W-1:0] ra, rb;
            ra = rand_bcd();
            rb = (k % 7 == 0) ? ra : rand_bcd();
            run_op("rand", ra, rb, 1'b0);
        end

        start_held_high();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bcd_serial_subtractor.md
Name: bcd_serial_subtractor

Overview:
- Digit-serial multi-digit BCD subtractor: computes A − B by 10's complement addition, A + 9's-complement(B) + 1, one digit per clock, least significant digit (LSD) first.
- If the result is negative, the block converts the 10's-complement result back to sign-magnitude with a second digit-serial recomplement pass.
- This is the restoring end of the 9's-complement path used by the combinational complementer.
- Sits between operand registers and a display/BCD output stage.

Parameters:
- DIGITS, 4, number of BCD digits per operand (≥1).

Ports:
- clock  input  1  rising-edge clock.
- reset_b  input  1  synchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- a_bcd  input  4*DIGITS  minuend, packed BCD, digit 0 at [3:0].
- b_bcd  input  4*DIGITS  subtrahend, packed BCD.
- busy  output  1  high from the edge that accepts start until the edge that asserts done.
- done  output  1  one-cycle pulse; result, negative and err are valid from this cycle.
- result  output  4*DIGITS  magnitude of A − B, packed BCD.
- negative  output  1  1 when A < B.
- err  output  1  1 if any a_bcd/b_bcd digit was > 9 at capture.

Behaviour:
- Reset (reset_b=0 at a rising edge):
  - state IDLE; busy=0, done=0, result=0, negative=0, err=0.
  - All internal digit counters and carries cleared.
  - Takes effect mid-operation; the operation in flight is abandoned with no done pulse.
- IDLE:
  - On an edge with start=1: capture a_bcd, b_bcd; compute err from the captured digits; carry=1; digit index=0; busy=1; go to SUB.
  - start=0: remain in IDLE; outputs hold their last values.
- SUB, one digit per edge, index 0..DIGITS-1:
  - s = a_i + (9 − b_i) + carry, 5-bit.
  - If s > 9: digit = s + 6 (low 4 bits) and carry_out=1; else digit = s and carry_out=0.
  - Store the digit into result at index i.
  - After digit DIGITS-1, go to CHECK.
- CHECK, one edge:
  - Final carry=1 (A ≥ B): negative=0, done=1, busy=0, go to DONE.
  - Final carry=0 (A < B): negative=1, carry=1, index=0, go to RECOMP.
- RECOMP, one digit per edge, index 0..DIGITS-1:
  - r_i ← BCD-corrected (9 − r_i) + carry, using the same correction rule as SUB.
  - The edge that processes digit DIGITS-1 also sets done=1, busy=0, and goes to DONE.
- DONE:
  - done is high for exactly this one cycle.
  - Next edge: done=0, go to IDLE.
  - result, negative and err hold until the next accepted start.
- Latency, counting the start-sampling edge as edge 0:
  - done is visible after edge DIGITS+1 when A ≥ B.
  - done is visible after edge 2*DIGITS+1 when A < B.
  - For DIGITS=4: 5 cycles and 9 cycles.
- Boundary conditions:
  - start while busy, or in DONE: ignored. Operand inputs may change freely after capture.
  - A == B: carry=1, so result=0 and negative=0. Negative zero is never produced.
  - Borrow out of the most significant digit is discarded. The magnitude always fits in DIGITS digits.
  - err=1: the operation still runs to done with the same timing. result and negative are don't-care.
  - start held high continuously: a new operation begins on the first edge in IDLE after DONE.

Test Plan:
- DIGITS=4, A=0042, B=0017, start for 1 cycle -> done after edge 5; result=0025, negative=0, err=0; busy high for edges 1–5.
- A=0017, B=0042 -> done after edge 9; result=0025, negative=1.
- A=1234, B=1234 -> result=0000, negative=0, latency 5; then A=0000, B=9999 -> result=9999, negative=1, latency 9.
- Digit 9/0 carry chain: A=1000, B=0001 -> result=0999, negative=0.
- Pulse start again at edge 3 of an operation -> ignored; exactly one done pulse; result matches the first operands.
- Drive reset_b=0 for 1 edge during RECOMP -> busy=0, done=0, result=0, negative=0 on the next cycle; no done pulse follows. A=00A0, B=0001 -> err=1 at done.
